// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor: A - B via A + nines(B) + 1, one digit per clock, LSD first.
// Results (diff/borrow/invalid) are registered and only change when an operation completes.
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  borrow,
  output logic                  invalid,
  output logic                  busy,
  output logic                  done
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            borrow_q, borrow_d, invalid_q, invalid_d;

  logic [3:0]      ad, bd, digit;
  logic [4:0]      raw;
  logic            carry_nx;
  logic [W+3:0]    res_shift;
  logic            in_bad;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // One ten's-complement digit step on the current least-significant pair.
  always_comb begin
    ad        = a_q[3:0];
    bd        = b_q[3:0];
    raw       = {1'b0, ad} + (5'd9 - {1'b0, bd}) + {4'd0, carry_q};
    carry_nx  = (raw > 5'd9);
    digit     = carry_nx ? (raw[3:0] + 4'd6) : raw[3:0];
    res_shift = {digit, res_q};
    in_bad    = has_bad_digit(a) | has_bad_digit(b);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    invalid_d = invalid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          carry_d = 1'b1;
          cnt_d   = '0;
          if (in_bad) begin
            state_d   = DONE;
            diff_d    = '0;
            borrow_d  = 1'b0;
            invalid_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        res_d   = res_shift[W+3:4];
        carry_d = carry_nx;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          state_d   = DONE;
          diff_d    = res_shift[W+3:4];
          borrow_d  = ~carry_nx;
          invalid_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      invalid_q <= invalid_d;
    end
  end

  assign diff    = diff_q;
  assign borrow  = borrow_q;
  assign invalid = invalid_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Bench for bcd_subtractor_serial: vector table, handshake corner cases, and random ops
// checked against an integer-arithmetic reference.
module tb_bcd_subtractor_serial;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic [W-1:0]  diff;
  logic          borrow, invalid, busy, done;

  int tests = 0;
  int fails = 0;

  bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .diff(diff), .borrow(borrow), .invalid(invalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         inv;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decode digits to integers, subtract, wrap negative by 10^DIGITS.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] md, output logic mbo, output logic minv);
    longint av = 0, bv = 0, dv, modv = 1;
    minv = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ma[4*i +: 4] > 9 || mb[4*i +: 4] > 9) minv = 1'b1;
      av = av * 10 + ma[4*i +: 4];
      bv = bv * 10 + mb[4*i +: 4];
      modv = modv * 10;
    end
    md = '0;
    mbo = 1'b0;
    if (!minv) begin
      dv = av - bv;
      mbo = (dv < 0);
      if (dv < 0) dv = dv + modv;
      for (int i = 0; i < DIGITS; i++) begin
        md[4*i +: 4] = 4'(dv % 10);
        dv = dv / 10;
      end
    end
  endfunction

  // Issue one op from IDLE and check latency, busy span, single-cycle done and results.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic ebo, input logic einv);
    int cyc, nbusy;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb;
    cyc = 1; nbusy = 0;
    while (!done && cyc < 3 * DIGITS + 10) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    check("latency", cyc, einv ? 1 : DIGITS + 1);
    check("busy_cycles", nbusy, einv ? 0 : DIGITS);
    check("diff", diff, ed);
    check("borrow", borrow, ebo);
    check("invalid", invalid, einv);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  vec_t vecs[8];
  logic [W-1:0] rd, ra, rb;
  logic rbo, rinv;
  int seen;

  initial begin
    vecs[0] = '{a:16'h5432, b:16'h1234, d:16'h4198, bo:1'b0, inv:1'b0};
    vecs[1] = '{a:16'h1234, b:16'h5432, d:16'h5802, bo:1'b1, inv:1'b0};
    vecs[2] = '{a:16'h0000, b:16'h0001, d:16'h9999, bo:1'b1, inv:1'b0};
    vecs[3] = '{a:16'h9999, b:16'h9999, d:16'h0000, bo:1'b0, inv:1'b0};
    vecs[4] = '{a:16'h9000, b:16'h0999, d:16'h8001, bo:1'b0, inv:1'b0};
    vecs[5] = '{a:16'h12A4, b:16'h0001, d:16'h0000, bo:1'b0, inv:1'b1};
    vecs[6] = '{a:16'h0001, b:16'h0000, d:16'h0001, bo:1'b0, inv:1'b0};
    vecs[7] = '{a:16'h0000, b:16'h0000, d:16'h0000, bo:1'b0, inv:1'b0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_invalid", invalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].inv);

    // Start while busy with different operands: ignored, original result, single done.
    @(negedge clk);
    a = 16'h5432; b = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h0000; b = 16'h0007; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("ign_done", done, 1);
    check("ign_diff", diff, 16'h4198);
    check("ign_borrow", borrow, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("ign_no_second_done", seen, 0);

    // Leave nonzero results, then reset mid-RUN.
    run_op(16'h1234, 16'h5432, 16'h5802, 1'b1, 1'b0);
    @(negedge clk);
    a = 16'h9000; b = 16'h0999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow", borrow, 0);
    check("midrst_invalid", invalid, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midrst_quiet", seen, 0);
    run_op(16'h9000, 16'h0999, 16'h8001, 1'b0, 1'b0);

    // Random operands, some with an out-of-range nibble.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      model(ra, rb, rd, rbo, rinv);
      run_op(ra, rb, rd, rbo, rinv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_subtractor_serial.md
# bcd_subtractor_serial

Digit-serial multi-digit BCD subtractor computing A − B, one decimal digit per clock, least-significant digit first, using the ten's-complement method (A + nines-complement(B) + 1) with per-digit decimal correction. It is the inverse arithmetic companion to the existing BCD adder datapath and uses the same 4-bit-per-digit packed BCD encoding. It sits behind a start/done handshake, so a controller or bench can issue an operation and collect the result and borrow flag.

## Interface
- DIGITS, 4: number of BCD digits per operand. Legal range is 1..8.
- clk  input  1  sole clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on the clk rising edge
- start  input  1  request; accepted only when the FSM is in IDLE
- a  input  4*DIGITS  minuend, packed BCD; digit i is a[4i+3:4i]
- b  input  4*DIGITS  subtrahend, packed BCD, same packing as a
- diff  output  4*DIGITS  result, packed BCD; ten's complement of |A−B| when borrow=1
- borrow  output  1  1 when A < B
- invalid  output  1  1 when any digit of the captured a or b exceeds 9
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse marking a valid diff/borrow/invalid

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on start=1 when both captured operands are valid.
  - IDLE → DONE on start=1 when either operand contains a digit above 9.
  - RUN → DONE after DIGITS digit steps.
  - DONE → IDLE unconditionally.
- On acceptance, a and b are copied into internal shift registers. Internal carry is set to 1, the digit counter is set to 0, and invalid is computed from the captured values.
- Each RUN step takes the current LSD pair ad and bd and computes raw = ad + (9 − bd) + carry, which lies in 0..19.
  - If raw > 9: digit = raw − 10, which equals (raw + 6) mod 16, and carry becomes 1.
  - Otherwise: digit = raw and carry becomes 0.
  - The digit is shifted into the MSD end of the working result, and both operand registers shift right by 4 bits.
- On entering DONE:
  - diff is loaded from the working result and borrow = ~carry.
  - If invalid: diff = 0 and borrow = 0.
- diff, borrow and invalid hold their values until the next accepted start completes. They do not change during RUN.
- start is ignored in RUN and DONE; there is no queuing. Changes to a or b after acceptance have no effect.
- Reset (rst_n=0 at an edge, in any state, including mid-RUN) forces IDLE. The operation in progress is discarded and no done is produced.

## Timing
- Reset values: diff=0, borrow=0, invalid=0, busy=0, done=0, state=IDLE.
- start is sampled at edge T0 and must be high for at least one cycle.
- busy=1 for cycles T0+1 through T0+DIGITS.
- done=1 for exactly one cycle, at T0+DIGITS+1. In that same cycle diff, borrow and invalid are already valid.
- Invalid path: done=1 at T0+1 and busy never asserts.
- The earliest next acceptance is at edge T0+DIGITS+2, which gives a throughput of one operation per DIGITS+2 cycles.
- start=1 held continuously re-triggers at each return to IDLE.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- DIGITS=4, a=0x5432, b=0x1234, start at T0 → done at T0+5, diff=0x4198, borrow=0, invalid=0; busy high for exactly 4 cycles.
- a=0x1234, b=0x5432 → diff=0x5802 (10000−4198), borrow=1. Also a=0x0000, b=0x0001 → diff=0x9999, borrow=1.
- Equal operands and correction extremes:
  - a=0x9999, b=0x9999 → diff=0x0000, borrow=0.
  - a=0x9000, b=0x0999 → diff=0x8001, borrow=0.
- Invalid input: a=0x12A4, b=0x0001 → done at T0+1, invalid=1, diff=0, borrow=0, busy never high. A following valid op clears invalid to 0.
- start pulsed at T0+2 while busy, with changed a/b → ignored; the original result appears at T0+5 and no second done occurs.
- rst_n=0 for one edge at T0+2 during RUN → state is IDLE, all outputs are 0, and no done pulse follows. A new start then completes normally.
